// File: rtl/dlx_mem_ctrl.sv
// dlx_mem_ctrl - memory sequencer between the DLX control unit and a
// single-ported 32-bit synchronous SRAM.
//
// The CU makes a byte/half/word request. This block turns it into an SRAM
// access with WAIT_STATES extra cycles and big-endian lane steering. It stalls
// the CU through o_mem_wait until the access completes. It also shares the
// SRAM with a word-only program-loader port, using round-robin arbitration.
//
// Ports
//   i_clock, i_reset            clock (rising edge), sync active-high reset
//   i_mem_read/i_mem_write      CU request (write wins if both are high)
//   i_mem_op                    00 byte, 01 half, 1x word
//   i_mem_addr, i_mem_wdata     byte address, right-justified write data
//   o_mem_rdata                 right-justified, zero-extended read data
//   o_mem_wait                  CU stall, combinational from the request
//   o_mem_align_err             one-cycle pulse on a misaligned CPU access
//   i_ldr_req/we/addr/wdata     loader request (word access only)
//   o_ldr_gnt, o_ldr_done       loader ownership / completion pulse
//   o_ram_cs/we/be/addr/wdata   SRAM command, i_ram_rdata SRAM read data
module dlx_mem_ctrl #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_mem_op,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_wait,
  output logic        o_mem_align_err,
  input  logic        i_ldr_req,
  input  logic        i_ldr_we,
  input  logic [31:0] i_ldr_addr,
  input  logic [31:0] i_ldr_wdata,
  output logic        o_ldr_gnt,
  output logic        o_ldr_done,
  output logic        o_ram_cs,
  output logic        o_ram_we,
  output logic [3:0]  o_ram_be,
  output logic [29:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;

  localparam logic [3:0] LP_WLOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      r_state;
  logic [3:0]  r_wcnt;
  logic        r_last_ldr;
  logic        r_owner_ldr;
  logic [1:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_ram_cs;
  logic        r_ram_we;
  logic [3:0]  r_ram_be;
  logic [29:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [31:0] r_mem_rdata;
  logic        r_align_err;
  logic        r_ldr_gnt;
  logic        r_ldr_done;
  logic        r_cpu_done;

  logic w_cpu_req;
  logic w_grant_ldr;
  logic w_misalign;
  logic w_enter_done;
  logic w_unused;

  // Big-endian byte enables: bit 3 is the lowest byte address.
  function automatic logic [3:0] f_be(input logic [1:0] op, input logic [1:0] lane);
    case (op)
      2'b00:   f_be = 4'b1000 >> lane;
      2'b01:   f_be = lane[1] ? 4'b0011 : 4'b1100;
      default: f_be = 4'b1111;
    endcase
  endfunction

  // Replicate the right-justified data across all lanes so be alone selects it.
  function automatic logic [31:0] f_wdata(input logic [1:0] op, input logic [31:0] wd);
    case (op)
      2'b00:   f_wdata = {4{wd[7:0]}};
      2'b01:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  // Move the addressed lane down to bit 0 and zero-extend.
  function automatic logic [31:0] f_rdata(input logic [1:0] op, input logic [1:0] lane,
                                          input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {~lane, 3'b000};
    case (op)
      2'b00:   f_rdata = {24'd0, sh[7:0]};
      2'b01:   f_rdata = lane[1] ? {16'd0, rd[15:0]} : {16'd0, rd[31:16]};
      default: f_rdata = rd;
    endcase
  endfunction

  assign w_cpu_req   = i_mem_read | i_mem_write;
  // A tie goes to whichever source did not own the previous access.
  assign w_grant_ldr = i_ldr_req & (~w_cpu_req | ~r_last_ldr);
  assign w_misalign  = (i_mem_op == 2'b00) ? 1'b0 :
                       (i_mem_op == 2'b01) ? i_mem_addr[0] :
                                             (i_mem_addr[1:0] != 2'b00);
  assign w_enter_done = ((r_state == ST_ACCESS) && (WAIT_STATES == 0)) ||
                        ((r_state == ST_WAIT) && (r_wcnt == 4'd0));
  assign w_unused     = ^i_ldr_addr[1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= 4'd0;
      r_last_ldr  <= 1'b1;
      r_owner_ldr <= 1'b0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_be    <= 4'd0;
      r_ram_addr  <= 30'd0;
      r_ram_wdata <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_align_err <= 1'b0;
      r_ldr_gnt   <= 1'b0;
      r_ldr_done  <= 1'b0;
      r_cpu_done  <= 1'b0;
    end else begin
      r_align_err <= 1'b0;
      r_ldr_done  <= 1'b0;
      r_cpu_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ldr) begin
            r_owner_ldr <= 1'b1;
            r_last_ldr  <= 1'b1;
            r_ldr_gnt   <= 1'b1;
            r_op        <= 2'b10;
            r_lane      <= 2'b00;
            r_ram_cs    <= 1'b1;
            r_ram_we    <= i_ldr_we;
            r_ram_be    <= 4'b1111;
            r_ram_addr  <= i_ldr_addr[31:2];
            r_ram_wdata <= i_ldr_wdata;
            r_state     <= ST_ACCESS;
          end else if (w_cpu_req) begin
            r_owner_ldr <= 1'b0;
            r_last_ldr  <= 1'b0;
            if (w_misalign) begin
              // Rejected without touching the SRAM.
              r_align_err <= 1'b1;
              r_cpu_done  <= 1'b1;
              r_mem_rdata <= 32'd0;
              r_state     <= ST_DONE;
            end else begin
              r_op        <= i_mem_op;
              r_lane      <= i_mem_addr[1:0];
              r_ram_cs    <= 1'b1;
              r_ram_we    <= i_mem_write;
              r_ram_be    <= f_be(i_mem_op, i_mem_addr[1:0]);
              r_ram_addr  <= i_mem_addr[31:2];
              r_ram_wdata <= f_wdata(i_mem_op, i_mem_wdata);
              r_state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (WAIT_STATES != 0) begin
            r_wcnt  <= LP_WLOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
        end
        default: begin
          r_ldr_gnt <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase

      // Last access cycle: capture read data and release the SRAM.
      if (w_enter_done) begin
        r_ram_cs    <= 1'b0;
        r_ram_we    <= 1'b0;
        r_mem_rdata <= f_rdata(r_op, r_lane, i_ram_rdata);
        if (r_owner_ldr) r_ldr_done <= 1'b1;
        else             r_cpu_done <= 1'b1;
        r_state     <= ST_DONE;
      end
    end
  end

  assign o_mem_wait      = w_cpu_req & ~r_cpu_done;
  assign o_mem_rdata     = r_mem_rdata;
  assign o_mem_align_err = r_align_err;
  assign o_ldr_gnt       = r_ldr_gnt;
  assign o_ldr_done      = r_ldr_done;
  assign o_ram_cs        = r_ram_cs;
  assign o_ram_we        = r_ram_we;
  assign o_ram_be        = r_ram_be;
  assign o_ram_addr      = r_ram_addr;
  assign o_ram_wdata     = r_ram_wdata;

endmodule

// File: tb/tb_dlx_mem_ctrl.sv
// Directed testbench for dlx_mem_ctrl: one instance with WAIT_STATES=2 for most
// scenarios and a second instance with WAIT_STATES=0 for the minimum latency.
module tb_dlx_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, ldr_req, ldr_we;
  logic [1:0]  op;
  logic [31:0] addr, wdata, ldr_addr, ldr_wdata, ram_rdata;
  logic [31:0] mem_rdata;
  logic        mem_wait, align_err, ldr_gnt, ldr_done, ram_cs, ram_we;
  logic [3:0]  ram_be;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;

  logic        rd0;
  logic [1:0]  op0;
  logic [31:0] addr0;
  logic [31:0] mem_rdata0;
  logic        mem_wait0, align_err0, ldr_gnt0, ldr_done0, ram_cs0, ram_we0;
  logic [3:0]  ram_be0;
  logic [29:0] ram_addr0;
  logic [31:0] ram_wdata0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dlx_mem_ctrl #(.WAIT_STATES(2)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_mem_read(rd), .i_mem_write(wr), .i_mem_op(op),
    .i_mem_addr(addr), .i_mem_wdata(wdata),
    .o_mem_rdata(mem_rdata), .o_mem_wait(mem_wait), .o_mem_align_err(align_err),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .o_ldr_gnt(ldr_gnt), .o_ldr_done(ldr_done),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_be(ram_be),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  dlx_mem_ctrl #(.WAIT_STATES(0)) dut0 (
    .i_clock(clk), .i_reset(rst),
    .i_mem_read(rd0), .i_mem_write(1'b0), .i_mem_op(op0),
    .i_mem_addr(addr0), .i_mem_wdata(32'd0),
    .o_mem_rdata(mem_rdata0), .o_mem_wait(mem_wait0), .o_mem_align_err(align_err0),
    .i_ldr_req(1'b0), .i_ldr_we(1'b0), .i_ldr_addr(32'd0), .i_ldr_wdata(32'd0),
    .o_ldr_gnt(ldr_gnt0), .o_ldr_done(ldr_done0),
    .o_ram_cs(ram_cs0), .o_ram_we(ram_we0), .o_ram_be(ram_be0),
    .o_ram_addr(ram_addr0), .o_ram_wdata(ram_wdata0), .i_ram_rdata(ram_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 0; wr = 0; op = 2'b10; addr = 0; wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ram_rdata = 0;
    rd0 = 0; op0 = 2'b10; addr0 = 0;
    next_cycle(); next_cycle();
    n_tests++;
    if ({ram_cs, ram_we, ram_be, ram_addr, ram_wdata} !== 68'd0) begin
      n_fail++; $display("FAIL reset_ram: got cs=%b we=%b be=%b addr=%h wd=%h required all 0",
                         ram_cs, ram_we, ram_be, ram_addr, ram_wdata);
    end
    n_tests++;
    if ({mem_rdata, align_err, ldr_gnt, ldr_done} !== 35'd0) begin
      n_fail++; $display("FAIL reset_outs: got rdata=%h aerr=%b gnt=%b done=%b required all 0",
                         mem_rdata, align_err, ldr_gnt, ldr_done);
    end
    n_tests++;
    if (mem_wait !== 1'b0) begin
      n_fail++; $display("FAIL reset_wait_idle: got %b required 0", mem_wait);
    end
    rd = 1; #1;
    n_tests++;
    if (mem_wait !== 1'b1) begin
      n_fail++; $display("FAIL reset_wait_follows: got %b required 1", mem_wait);
    end
    rd = 0; rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_word_read();
    rd = 1; op = 2'b10; addr = 32'h10; ram_rdata = 32'hDEADBEEF;
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) next_cycle();
      n_tests++;
      if (ram_cs !== (c >= 1 && c <= 3)) begin
        n_fail++; $display("FAIL wr_cs c%0d: got %b required %b", c, ram_cs, (c >= 1 && c <= 3));
      end
      n_tests++;
      if (mem_wait !== (c <= 3)) begin
        n_fail++; $display("FAIL wr_wait c%0d: got %b required %b", c, mem_wait, (c <= 3));
      end
    end
    n_tests++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_rdata: got %h required deadbeef", mem_rdata);
    end
    rd = 0;
    next_cycle();
  endtask

  task automatic test_word_read_addr();
    rd = 1; op = 2'b11; addr = 32'h10; ram_rdata = 32'h01020304;
    next_cycle();
    n_tests++;
    if ({ram_addr, ram_be, ram_we} !== {30'h4, 4'b1111, 1'b0}) begin
      n_fail++; $display("FAIL w11_cmd: got addr=%h be=%b we=%b required 4/1111/0",
                         ram_addr, ram_be, ram_we);
    end
    next_cycle(); next_cycle(); next_cycle();
    n_tests++;
    if (mem_rdata !== 32'h01020304) begin
      n_fail++; $display("FAIL w11_rdata: got %h required 01020304", mem_rdata);
    end
    rd = 0;
    next_cycle();
  endtask

  task automatic test_byte_write();
    wr = 1; op = 2'b00; addr = 32'h13; wdata = 32'h000000A5;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c <= 3) begin
        n_tests++;
        if ({ram_cs, ram_we, ram_be, ram_wdata, ram_addr} !== {1'b1, 1'b1, 4'b0001, 32'hA5A5A5A5, 30'h4}) begin
          n_fail++; $display("FAIL bw_cmd c%0d: got cs=%b we=%b be=%b wd=%h addr=%h required 1/1/0001/a5a5a5a5/4",
                             c, ram_cs, ram_we, ram_be, ram_wdata, ram_addr);
        end
      end else begin
        n_tests++;
        if ({ram_cs, ram_we, mem_wait} !== 3'b000) begin
          n_fail++; $display("FAIL bw_done: got cs=%b we=%b wait=%b required 000", ram_cs, ram_we, mem_wait);
        end
      end
    end
    wr = 0;
    next_cycle();
  endtask

  task automatic test_half_byte_read();
    logic [31:0] addrs [3];
    logic [1:0]  ops   [3];
    logic [3:0]  bes   [3];
    logic [31:0] exps  [3];
    addrs = '{32'h12, 32'h10, 32'h11};
    ops   = '{2'b01, 2'b01, 2'b00};
    bes   = '{4'b0011, 4'b1100, 4'b0100};
    exps  = '{32'h00003344, 32'h00001122, 32'h00000022};
    ram_rdata = 32'h11223344;
    for (int i = 0; i < 3; i++) begin
      rd = 1; op = ops[i]; addr = addrs[i];
      next_cycle();
      n_tests++;
      if (ram_be !== bes[i]) begin
        n_fail++; $display("FAIL hb_be%0d: got %b required %b", i, ram_be, bes[i]);
      end
      next_cycle(); next_cycle(); next_cycle();
      n_tests++;
      if (mem_rdata !== exps[i] || mem_wait !== 1'b0) begin
        n_fail++; $display("FAIL hb_rdata%0d: got %h wait=%b required %h wait=0",
                           i, mem_rdata, mem_wait, exps[i]);
      end
      rd = 0;
      next_cycle();
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2];
    logic [1:0]  ops   [2];
    addrs = '{32'h02, 32'h13};
    ops   = '{2'b10, 2'b01};
    for (int i = 0; i < 2; i++) begin
      rd = 1; op = ops[i]; addr = addrs[i]; #1;
      n_tests++;
      if (mem_wait !== 1'b1 || ram_cs !== 1'b0) begin
        n_fail++; $display("FAIL ma_c0_%0d: got wait=%b cs=%b required 1/0", i, mem_wait, ram_cs);
      end
      next_cycle();
      n_tests++;
      if ({align_err, mem_wait, ram_cs, mem_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        n_fail++; $display("FAIL ma_c1_%0d: got aerr=%b wait=%b cs=%b rdata=%h required 1/0/0/0",
                           i, align_err, mem_wait, ram_cs, mem_rdata);
      end
      rd = 0;
      next_cycle();
      n_tests++;
      if (align_err !== 1'b0 || ram_cs !== 1'b0) begin
        n_fail++; $display("FAIL ma_c2_%0d: got aerr=%b cs=%b required 0/0", i, align_err, ram_cs);
      end
    end
  endtask

  task automatic test_arbitration();
    int done_cnt;
    rst = 1; next_cycle(); rst = 0;
    // cycle 0: tie, CPU wins
    rd = 1; op = 2'b10; addr = 32'h20; ram_rdata = 32'h55667788;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h40; ldr_wdata = 32'hCAFEF00D;
    next_cycle();
    n_tests++;
    if ({ram_addr, ldr_gnt, ram_we} !== {30'h8, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL arb_cpu_first: got addr=%h gnt=%b we=%b required 8/0/0", ram_addr, ldr_gnt, ram_we);
    end
    next_cycle(); next_cycle(); next_cycle();
    n_tests++;
    if ({mem_wait, mem_rdata, ldr_done} !== {1'b0, 32'h55667788, 1'b0}) begin
      n_fail++; $display("FAIL arb_cpu_done: got wait=%b rdata=%h ldone=%b required 0/55667788/0",
                         mem_wait, mem_rdata, ldr_done);
    end
    done_cnt = 0;
    // cycles 5..9: loader owns the SRAM
    for (int c = 5; c <= 9; c++) begin
      next_cycle();
      if (ldr_done === 1'b1) done_cnt++;
      n_tests++;
      if (ldr_gnt !== (c >= 6) || mem_wait !== 1'b1) begin
        n_fail++; $display("FAIL arb_ldr_gnt c%0d: got gnt=%b wait=%b required %b/1", c, ldr_gnt, mem_wait, (c >= 6));
      end
      if (c == 6) begin
        n_tests++;
        if ({ram_we, ram_be, ram_addr, ram_wdata} !== {1'b1, 4'b1111, 30'h10, 32'hCAFEF00D}) begin
          n_fail++; $display("FAIL arb_ldr_cmd: got we=%b be=%b addr=%h wd=%h required 1/1111/10/cafef00d",
                             ram_we, ram_be, ram_addr, ram_wdata);
        end
      end
    end
    ldr_req = 0;
    next_cycle();
    if (ldr_done === 1'b1) done_cnt++;
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL arb_ldr_done_count: got %0d required 1", done_cnt);
    end
    // cycle 10: second tie, CPU must win again
    ldr_req = 1; ldr_we = 0; ram_rdata = 32'h0BADF00D;
    next_cycle();
    n_tests++;
    if ({ram_addr, ldr_gnt, ram_cs} !== {30'h8, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL arb_alternate: got addr=%h gnt=%b cs=%b required 8/0/1", ram_addr, ldr_gnt, ram_cs);
    end
    next_cycle(); next_cycle(); next_cycle();
    rd = 0;
    next_cycle(); next_cycle();
    n_tests++;
    if ({ldr_gnt, ram_we, ram_addr} !== {1'b1, 1'b0, 30'h10}) begin
      n_fail++; $display("FAIL arb_ldr_read: got gnt=%b we=%b addr=%h required 1/0/10", ldr_gnt, ram_we, ram_addr);
    end
    next_cycle(); next_cycle(); next_cycle();
    n_tests++;
    if ({ldr_done, mem_rdata} !== {1'b1, 32'h0BADF00D}) begin
      n_fail++; $display("FAIL arb_ldr_rdata: got done=%b rdata=%h required 1/0badf00d", ldr_done, mem_rdata);
    end
    ldr_req = 0;
    next_cycle();
  endtask

  task automatic test_zero_wait();
    rd0 = 1; op0 = 2'b10; addr0 = 32'h8; ram_rdata = 32'h12345678;
    #1;
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) next_cycle();
      n_tests++;
      if (ram_cs0 !== (c == 1) || mem_wait0 !== (c <= 1)) begin
        n_fail++; $display("FAIL w0 c%0d: got cs=%b wait=%b required %b/%b", c, ram_cs0, mem_wait0, (c == 1), (c <= 1));
      end
    end
    n_tests++;
    if (mem_rdata0 !== 32'h12345678) begin
      n_fail++; $display("FAIL w0_rdata: got %h required 12345678", mem_rdata0);
    end
    rd0 = 0;
    next_cycle();
  endtask

  task automatic test_reset_abort();
    rd = 1; op = 2'b10; addr = 32'h30; ram_rdata = 32'h00000099;
    next_cycle(); next_cycle();
    rst = 1;
    next_cycle();
    // cycle 3: reset took effect, access aborted
    n_tests++;
    if ({ram_cs, ram_addr, ldr_done, mem_wait, mem_rdata} !== {1'b0, 30'h0, 1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL ra_abort: got cs=%b addr=%h ldone=%b wait=%b rdata=%h required 0/0/0/1/0",
                         ram_cs, ram_addr, ldr_done, mem_wait, mem_rdata);
    end
    rst = 0;
    for (int c = 4; c <= 7; c++) begin
      next_cycle();
      n_tests++;
      if (ram_cs !== (c <= 6) || mem_wait !== (c <= 6)) begin
        n_fail++; $display("FAIL ra_rerun c%0d: got cs=%b wait=%b required %b/%b", c, ram_cs, mem_wait, (c <= 6), (c <= 6));
      end
    end
    n_tests++;
    if (mem_rdata !== 32'h00000099) begin
      n_fail++; $display("FAIL ra_rdata: got %h required 00000099", mem_rdata);
    end
    rd = 0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_word_read_addr();
    test_byte_write();
    test_half_byte_read();
    test_misalign();
    test_arbitration();
    test_zero_wait();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dlx_mem_ctrl.md
# dlx_mem_ctrl

Memory sequencer between the non-pipelined DLX control unit and a single-ported 32-bit synchronous SRAM. It turns the CU's MemRead/MemWrite/MemOP request into a timed SRAM access with configurable wait states, and handles big-endian byte and half-word lanes and alignment checking. It drives MemWait back to the CU until the access completes, and arbitrates the SRAM between the CPU and a program-loader port.

## Interface
- WAIT_STATES, default 2: extra SRAM cycles after the address cycle, 0..15.
- clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- MemRead  in  1  CU read request; held until MemWait is low.
- MemWrite  in  1  CU write request; held until MemWait is low.
- MemOP  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- MemAddr  in  32  byte address from MAR.
- MemWdata  in  32  write data from MDR, right-justified.
- MemRdata  out  32  read data to MDR, right-justified, zero-extended.
- MemWait  out  1  CU stall.
- MemAlignErr  out  1  one-cycle pulse on a misaligned CPU access.
- ldr_req  in  1  loader request; held until ldr_done.
- ldr_we  in  1  loader write (1) / read (0).
- ldr_addr  in  32  loader address; only bits 31:2 are used, word access only.
- ldr_wdata  in  32  loader write data.
- ldr_gnt  out  1  loader owns the SRAM.
- ldr_done  out  1  one-cycle completion pulse; MemRdata is valid in the same cycle.
- ram_cs  out  1  SRAM chip select.
- ram_we  out  1  SRAM write enable.
- ram_be  out  4  byte enables; bit 3 is bits 31:24 (lowest byte address).
- ram_addr  out  30  word address (addr[31:2]).
- ram_wdata  out  32  SRAM write data.
- ram_rdata  in  32  SRAM read data; valid at the end of the last access cycle.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Only one source requesting: grant it.
  - Both requesting: grant the source not granted last. The last-owner register resets to loader, so the CPU wins the first tie.
  - The CPU request is MemRead|MemWrite. If both are high, the access is a write.
- Misaligned CPU request (half with addr[0]=1, or word/11 with addr[1:0]≠00):
  - Go IDLE→DONE with no SRAM cycle.
  - MemAlignErr pulses in DONE; MemRdata=0.
- Aligned request: IDLE→ACCESS, registering ram_cs=1, ram_we, ram_be, ram_addr, ram_wdata.
  - ACCESS→WAIT if WAIT_STATES>0, otherwise →DONE.
  - WAIT counts down WAIT_STATES cycles with all ram_* outputs held, then →DONE.
  - ram_cs and ram_we drop on entry to DONE.
- Byte lanes (big-endian):
  - byte: be = 4'b1000 >> addr[1:0]; wdata = low byte replicated ×4.
  - half: be = addr[1] ? 0011 : 1100; wdata = low half replicated ×2.
  - word: be = 1111.
  - Read: the selected lane is shifted to bit 0 and zero-extended.
- Loader accesses are always word accesses with be=1111. ldr_gnt is high from ACCESS through DONE while the loader owns the SRAM.
- DONE→IDLE unconditionally. A request still high in the cycle after DONE starts a new access, so the CU must drop its request once MemWait is low.
- MemWait = (MemRead|MemWrite) & ~cpu_done.
  - This is combinational from the request.
  - cpu_done is high in DONE while the CPU owns the access.
- MemRdata is registered on entry to DONE and holds until the next DONE.

## Timing
- Reset values:
  - State IDLE; wait counter 0; last owner = loader.
  - ram_cs, ram_we, ram_be, ram_addr, ram_wdata = 0.
  - MemRdata = 0; MemAlignErr = 0; ldr_gnt = 0; ldr_done = 0.
  - MemWait still follows the request during reset.
- Aligned access with the request first seen in IDLE at cycle 0:
  - ram_cs high in cycles 1..1+W (W = WAIT_STATES).
  - DONE in cycle 2+W, with MemWait low and MemRdata valid.
  - Total latency 2+W cycles.
- Misaligned access: DONE in cycle 1.
- Reset asserted in any state: the next edge returns the FSM to IDLE and all registered outputs to their reset values. The aborted access is not completed. A request still held after Reset drops restarts from ACCESS.
- A loader request arriving while the CPU is in ACCESS or WAIT waits; it is granted in the IDLE cycle after DONE.

## Test plan
- W=2, word read at 0x10 with ram_rdata=0xDEADBEEF → ram_cs high cycles 1–3, ram_addr=0x4, MemWait high cycles 0–3, MemRdata=0xDEADBEEF and MemWait=0 in cycle 4.
- Byte write at 0x13 with MemWdata=0x000000A5 → ram_be=0001, ram_wdata=0xA5A5A5A5, ram_we=1 during ACCESS and WAIT.
- Half read at 0x12 with ram_rdata=0x11223344 → ram_be=0011, MemRdata=0x00003344; half read at 0x10 → 0x00001122.
- Word read at 0x02 → ram_cs never asserted, MemAlignErr=1 in cycle 1, MemRdata=0, MemWait low in cycle 1.
- CPU and loader request in the same cycle after reset, both held → CPU served first, ldr_gnt rises in the next ACCESS, ldr_done pulses once; a repeated tie is granted to the CPU again (alternation).
- W=0 → DONE in cycle 2. Reset pulsed during WAIT → ram_cs=0 on the next edge, no ldr_done or cpu_done, and the held request is re-executed with full latency.
